// File: rtl/crc_goback_unit.sv
// Undoes the trailing zero-byte padding of an end-of-packet CRC by running the
// CRC LFSR backwards one byte per clock, then applies the final XOR.
module crc_goback_unit #(
  parameter int          MOD_WIDTH = 12,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] XOR_OUT   = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 crc_en_in,
  input  logic [31:0]          crc_in,
  input  logic [MOD_WIDTH-1:0] mod_in,
  output logic                 busy,
  output logic [31:0]          crc_out,
  output logic                 crc_vld,
  output logic                 ovf_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic [31:0]          work_reg, work_next;
  logic [MOD_WIDTH-1:0] cnt_reg, cnt_next;
  logic [31:0]          crc_out_reg, crc_out_next;
  logic                 crc_vld_reg, crc_vld_next;
  logic                 ovf_err_reg, ovf_err_next;

  // Eight chained reverse bit steps. POLY[0]=1, so bit 0 of the forward
  // result carries the bit that was shifted out of position 31.
  logic [8:0][31:0] step_chain;
  assign step_chain[0] = work_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev_step
      logic fb;
      assign fb = step_chain[gi][0];
      assign step_chain[gi+1] = ((step_chain[gi] ^ (fb ? POLY : 32'h0)) >> 1) | {fb, 31'h0};
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    work_next    = work_reg;
    cnt_next     = cnt_reg;
    crc_out_next = crc_out_reg;
    crc_vld_next = 1'b0;
    ovf_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (crc_en_in) begin
          work_next  = crc_in;
          cnt_next   = mod_in;
          state_next = RUN;
        end
      end
      RUN: begin
        // Strobes arriving mid-job are dropped and flagged, never queued.
        if (crc_en_in) ovf_err_next = 1'b1;
        if (cnt_reg != '0) begin
          work_next = step_chain[8];
          cnt_next  = cnt_reg - MOD_WIDTH'(1);
        end else begin
          crc_out_next = work_reg ^ XOR_OUT;
          crc_vld_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      work_reg    <= '0;
      cnt_reg     <= '0;
      crc_out_reg <= '0;
      crc_vld_reg <= 1'b0;
      ovf_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      work_reg    <= work_next;
      cnt_reg     <= cnt_next;
      crc_out_reg <= crc_out_next;
      crc_vld_reg <= crc_vld_next;
      ovf_err_reg <= ovf_err_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign crc_out = crc_out_reg;
  assign crc_vld = crc_vld_reg;
  assign ovf_err = ovf_err_reg;

endmodule

// File: tb/tb_crc_goback_unit.sv
// Directed and randomised checks of crc_goback_unit: two instances share the
// inputs, one with XOR_OUT=0 and one with XOR_OUT=0xFFFFFFFF.
module tb_crc_goback_unit;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        crc_en_in = 1'b0;
  logic [31:0] crc_in = 32'h0;
  logic [11:0] mod_in = 12'h0;
  logic        busy, crc_vld, ovf_err;
  logic [31:0] crc_out;
  logic        busy_x, crc_vld_x, ovf_err_x;
  logic [31:0] crc_out_x;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  crc_goback_unit #(.MOD_WIDTH(12), .POLY(POLY), .XOR_OUT(32'h00000000)) dut (
    .clk(clk), .rst(rst), .crc_en_in(crc_en_in), .crc_in(crc_in), .mod_in(mod_in),
    .busy(busy), .crc_out(crc_out), .crc_vld(crc_vld), .ovf_err(ovf_err)
  );

  crc_goback_unit #(.MOD_WIDTH(12), .POLY(POLY), .XOR_OUT(32'hFFFFFFFF)) dut_x (
    .clk(clk), .rst(rst), .crc_en_in(crc_en_in), .crc_in(crc_in), .mod_in(mod_in),
    .busy(busy_x), .crc_out(crc_out_x), .crc_vld(crc_vld_x), .ovf_err(ovf_err_x)
  );

  // Called at a negedge; drives a one-cycle strobe, returns at the next negedge.
  task automatic strobe(input logic [31:0] c, input logic [11:0] m);
    crc_en_in = 1'b1;
    crc_in    = c;
    mod_in    = m;
    @(negedge clk);
    crc_en_in = 1'b0;
  endtask

  // Counts cycles since the strobe cycle until crc_vld; -1 on timeout.
  task automatic wait_vld(input int limit, output int cyc);
    cyc = 1;
    while (crc_vld !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (crc_vld !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b1;
      checks++;
      if ({busy, crc_vld, ovf_err, crc_out} !== 35'h0 || {busy_x, crc_vld_x, ovf_err_x, crc_out_x} !== 35'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b vld=%b ovf=%b out=%h (x: %b %b %b %h), required all zero",
                 i, busy, crc_vld, ovf_err, crc_out, busy_x, crc_vld_x, ovf_err_x, crc_out_x);
      end
    end
    $display("reset: idle outputs observed for 6 cycles");
  endtask

  task automatic test_zero_depth();
    int cyc;
    strobe(32'hDEADBEEF, 12'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: busy=%b required 1", busy); end
    wait_vld(10, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL zero_latency: got %0d required 2", cyc); end
    checks++;
    if (crc_out !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_out: got %h required deadbeef", crc_out); end
    checks++;
    if (crc_vld_x !== 1'b1 || crc_out_x !== 32'h21524110) begin
      errors++; $display("FAIL zero_out_xor: vld=%b out=%h required 1 21524110", crc_vld_x, crc_out_x);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_fall: busy=%b required 0", busy); end
    $display("job: crc_in=deadbeef mod=0 crc_out=%h xor_out=%h latency=%0d", crc_out, crc_out_x, cyc);
    @(negedge clk);
    checks++;
    if (crc_vld !== 1'b0) begin errors++; $display("FAIL zero_vld_pulse: vld=%b required 0", crc_vld); end
  endtask

  task automatic test_one_two_bytes();
    int cyc;
    strobe(POLY, 12'd1);
    wait_vld(10, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL one_latency: got %0d required 3", cyc); end
    checks++;
    if (crc_out !== 32'h01000000) begin errors++; $display("FAIL one_out: got %h required 01000000", crc_out); end
    checks++;
    if (crc_out_x !== 32'hFEFFFFFF) begin errors++; $display("FAIL one_out_xor: got %h required feffffff", crc_out_x); end
    $display("job: crc_in=%h mod=1 crc_out=%h latency=%0d", POLY, crc_out, cyc);
    @(negedge clk);
    strobe(POLY, 12'd2);
    wait_vld(10, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL two_latency: got %0d required 4", cyc); end
    checks++;
    if (crc_out !== 32'h00010000) begin errors++; $display("FAIL two_out: got %h required 00010000", crc_out); end
    $display("job: crc_in=%h mod=2 crc_out=%h latency=%0d", POLY, crc_out, cyc);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    strobe(POLY, 12'd3);                // now at cycle +1 of job A
    @(negedge clk);                     // cycle +2
    strobe(32'h12345678, 12'd7);        // overrun strobe; now at cycle +3
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse: ovf_err=%b required 1", ovf_err); end
    @(negedge clk);                     // cycle +4
    checks++;
    if (ovf_err !== 1'b0 || crc_vld !== 1'b0) begin
      errors++; $display("FAIL ovf_single: ovf_err=%b vld=%b required 0 0", ovf_err, crc_vld);
    end
    @(negedge clk);                     // cycle +5: A's crc_vld cycle
    checks++;
    if (crc_vld !== 1'b1 || crc_out !== 32'h00000100) begin
      errors++; $display("FAIL b2b_a: vld=%b out=%h required 1 00000100", crc_vld, crc_out);
    end
    $display("job: crc_in=%h mod=3 crc_out=%h (overrun strobe dropped)", POLY, crc_out);
    strobe(32'h00000000, 12'd5);        // accepted in the vld cycle
    checks++;
    if (busy !== 1'b1 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b ovf=%b required 1 0", busy, ovf_err);
    end
    wait_vld(20, cyc);
    checks++;
    if (cyc !== 7 || crc_out !== 32'h00000000) begin
      errors++; $display("FAIL b2b_c: latency=%0d out=%h required 7 00000000", cyc, crc_out);
    end
    $display("job: crc_in=00000000 mod=5 crc_out=%h latency=%0d", crc_out, cyc);
    @(negedge clk);
  endtask

  task automatic test_max_depth();
    int cyc;
    strobe(POLY, 12'd1);
    wait_vld(10, cyc);
    @(negedge clk);
    strobe(32'h00000000, 12'd4095);
    wait_vld(5000, cyc);
    checks++;
    if (cyc !== 4097 || crc_out !== 32'h00000000) begin
      errors++; $display("FAIL max_depth: latency=%0d out=%h required 4097 00000000", cyc, crc_out);
    end
    $display("job: crc_in=00000000 mod=4095 crc_out=%h latency=%0d", crc_out, cyc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int seen_vld;
    strobe(32'h00000000, 12'd4095);
    repeat (99) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || crc_vld !== 1'b0 || crc_out !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b vld=%b out=%h required 0 0 00000000", busy, crc_vld, crc_out);
    end
    rst = 1'b1;
    seen_vld = 0;
    repeat (10) begin
      @(negedge clk);
      if (crc_vld === 1'b1 || busy === 1'b1) seen_vld++;
    end
    checks++;
    if (seen_vld !== 0) begin errors++; $display("FAIL reset_discard: active cycles=%0d required 0", seen_vld); end
    strobe(POLY, 12'd1);
    wait_vld(10, cyc);
    checks++;
    if (cyc !== 3 || crc_out !== 32'h01000000) begin
      errors++; $display("FAIL reset_next_job: latency=%0d out=%h required 3 01000000", cyc, crc_out);
    end
    $display("job: reset after 100 cycles; next crc_out=%h latency=%0d", crc_out, cyc);
    @(negedge clk);
  endtask

  task automatic test_random();
    int          cyc;
    logic [31:0] c, ref_c;
    logic [11:0] m;
    for (int j = 0; j < 20; j++) begin
      c = $urandom;
      m = 12'($urandom_range(0, 64));
      strobe(c, m);
      wait_vld(100, cyc);
      ref_c = crc_out;
      for (int b = 0; b < 8 * int'(m); b++)
        ref_c = (ref_c << 1) ^ (ref_c[31] ? POLY : 32'h0);
      checks++;
      if (cyc !== int'(m) + 2 || ref_c !== c) begin
        errors++;
        $display("FAIL random_%0d: latency=%0d fwd(crc_out)=%h required %0d %h", j, cyc, ref_c, int'(m) + 2, c);
      end
      $display("job: crc_in=%h mod=%0d crc_out=%h latency=%0d", c, m, crc_out, cyc);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero_depth();
    test_one_two_bytes();
    test_back_to_back();
    test_max_depth();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
